// File: rtl/ext_pkg.sv
// Shared definitions for the immediate extender: extension mode encodings.
package ext_pkg;
  localparam int EXT_MODE_W = 2;
  localparam logic [EXT_MODE_W-1:0] EXT_ZERO     = 2'd0;
  localparam logic [EXT_MODE_W-1:0] EXT_SIGN     = 2'd1;
  localparam logic [EXT_MODE_W-1:0] EXT_UPPER    = 2'd2;
  localparam logic [EXT_MODE_W-1:0] EXT_SIGN_SHL = 2'd3;
endpackage

// File: rtl/ext_core.sv
// Combinational immediate extender: widens imm_in to OUT_W bits in one of four modes.
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic [IN_W-1:0]       imm_in,
  input  logic [EXT_MODE_W-1:0] mode,
  output logic [OUT_W-1:0]      imm_out
);

  // Bits above the immediate; collapses to zero when IN_W == OUT_W.
  localparam logic [OUT_W-1:0] HI_MASK = ~((OUT_W'(1) << IN_W) - OUT_W'(1));

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] upper;
  logic [OUT_W-1:0] sshl;

  always_comb begin
    zext  = OUT_W'(imm_in);
    sext  = imm_in[IN_W-1] ? (zext | HI_MASK) : zext;
    upper = zext << (OUT_W - IN_W);
    sshl  = sext << BR_SHIFT;
    unique case (mode)
      EXT_ZERO:  imm_out = zext;
      EXT_SIGN:  imm_out = sext;
      EXT_UPPER: imm_out = upper;
      default:   imm_out = sshl;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender with valid/ready handshake and a 2-entry skid buffer
// (main register M drives the output, skid register S absorbs one stalled push).
module imm_ext_pipe
  import ext_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  input  logic [EXT_MODE_W-1:0] in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_neg,
  output logic [1:0]            occupancy
);

  if (IN_W > OUT_W || IN_W < 1 || BR_SHIFT >= OUT_W) begin : g_param_check
    $error("imm_ext_pipe: illegal parameters IN_W=%0d OUT_W=%0d BR_SHIFT=%0d",
           IN_W, OUT_W, BR_SHIFT);
  end

  logic             m_valid_q, m_valid_d;
  logic             s_valid_q, s_valid_d;
  logic [OUT_W-1:0] m_data_q,  m_data_d;
  logic [OUT_W-1:0] s_data_q,  s_data_d;
  logic [OUT_W-1:0] ext_val;
  logic             acc;
  logic             pop;

  ext_core #(
    .IN_W     (IN_W),
    .OUT_W    (OUT_W),
    .BR_SHIFT (BR_SHIFT)
  ) u_ext_core (
    .imm_in  (in_data),
    .mode    (in_mode),
    .imm_out (ext_val)
  );

  assign in_ready  = ~s_valid_q & ~Reset;
  assign acc       = in_valid & in_ready;
  assign pop       = m_valid_q & out_ready;
  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;
  assign out_neg   = m_data_q[OUT_W-1];
  assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};

  // S is only ever valid while M is valid, so an empty M implies an empty S.
  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;
    if (!m_valid_q) begin
      if (acc) begin
        m_valid_d = 1'b1;
        m_data_d  = ext_val;
      end
    end else if (pop) begin
      if (s_valid_q) begin
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else if (acc) begin
        m_data_d  = ext_val;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (acc) begin
      s_valid_d = 1'b1;
      s_data_d  = ext_val;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_data_q  <= '0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed mode/backpressure/reset tests, a
// parameter sweep, and random handshake traffic checked against a scoreboard queue.
module tb_imm_ext_pipe;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_neg;
  logic [1:0]  occupancy;

  logic        sw8_valid, sw8_in_ready, sw8_out_valid, sw8_neg;
  logic [7:0]  sw8_data;
  logic [1:0]  sw8_mode, sw8_occ;
  logic [15:0] sw8_out;
  logic        sw16_valid, sw16_in_ready, sw16_out_valid, sw16_neg;
  logic [15:0] sw16_data;
  logic [1:0]  sw16_mode, sw16_occ;
  logic [15:0] sw16_out;

  int          assert_count = 0;
  int          fail_count   = 0;
  int          pop_count    = 0;
  logic [31:0] exp_q[$];
  logic        held_valid   = 1'b0;
  logic [31:0] held_data    = '0;

  always #5 Clk = ~Clk;

  imm_ext_pipe dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_neg   (out_neg),
    .occupancy (occupancy)
  );

  imm_ext_pipe #(.IN_W(8), .OUT_W(16), .BR_SHIFT(1)) dut_sw8 (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_valid  (sw8_valid),
    .in_ready  (sw8_in_ready),
    .in_data   (sw8_data),
    .in_mode   (sw8_mode),
    .out_valid (sw8_out_valid),
    .out_ready (1'b1),
    .out_data  (sw8_out),
    .out_neg   (sw8_neg),
    .occupancy (sw8_occ)
  );

  imm_ext_pipe #(.IN_W(16), .OUT_W(16), .BR_SHIFT(2)) dut_sw16 (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_valid  (sw16_valid),
    .in_ready  (sw16_in_ready),
    .in_data   (sw16_data),
    .in_mode   (sw16_mode),
    .out_valid (sw16_out_valid),
    .out_ready (1'b1),
    .out_data  (sw16_out),
    .out_neg   (sw16_neg),
    .occupancy (sw16_occ)
  );

  function automatic logic [31:0] extRef(input logic [15:0] d, input logic [1:0] m);
    logic [31:0] s;
    s = {{16{d[15]}}, d};
    case (m)
      2'd0:    return {16'h0000, d};
      2'd1:    return s;
      2'd2:    return {d, 16'h0000};
      default: return {s[29:0], 2'b00};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic [1:0] m, input logic r);
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    out_ready = r;
  endtask

  task automatic nextCycle();
    @(posedge Clk);
    #1;
  endtask

  // Scoreboard sampled mid-cycle: what is seen here transfers on the next rising edge.
  always @(negedge Clk) begin
    if (Reset) begin
      exp_q.delete();
      held_valid = 1'b0;
    end else begin
      if (held_valid && out_valid)
        checkOutput("stall_stable", out_data, held_data);
      held_valid = out_valid && !out_ready;
      held_data  = out_data;
      if (out_valid && out_ready) begin
        pop_count++;
        if (exp_q.size() == 0)
          checkOutput("sb_unexpected_output", 32'd1, 32'd0);
        else
          checkOutput("sb_data", out_data, exp_q.pop_front());
      end
      if (in_valid && in_ready)
        exp_q.push_back(extRef(in_data, in_mode));
    end
  end

  initial begin
    logic [31:0] mode_exp [4];
    logic        neg_exp  [4];
    int          pops_before;

    mode_exp = '{32'h00008004, 32'hFFFF8004, 32'h80040000, 32'hFFFE0010};
    neg_exp  = '{1'b0, 1'b1, 1'b1, 1'b1};
    Reset = 1'b1;
    applyStimulus(1'b0, 16'h0, 2'd0, 1'b0);
    sw8_valid = 1'b0;  sw8_data = '0;  sw8_mode = '0;
    sw16_valid = 1'b0; sw16_data = '0; sw16_mode = '0;
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    repeat (3) nextCycle();
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data", out_data, 32'd0);
    checkOutput("reset_occupancy", 32'(occupancy), 32'd0);
    Reset = 1'b0;
    #1;
    checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);

    // Modes, one cycle latency
    nextCycle();
    for (int m = 0; m < 4; m++) begin
      applyStimulus(1'b1, 16'h8004, 2'(m), 1'b1);
      nextCycle();
      checkOutput($sformatf("mode%0d_valid", m), 32'(out_valid), 32'd1);
      checkOutput($sformatf("mode%0d_data", m), out_data, mode_exp[m]);
      checkOutput($sformatf("mode%0d_neg", m), 32'(out_neg), 32'(neg_exp[m]));
    end
    applyStimulus(1'b0, 16'h0, 2'd0, 1'b1);
    nextCycle();
    checkOutput("mode_drain_occ", 32'(occupancy), 32'd0);

    // Backpressure into the skid register
    applyStimulus(1'b1, 16'h0001, 2'd1, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 16'h0002, 2'd1, 1'b0);
    nextCycle();
    checkOutput("bp_occ_full", 32'(occupancy), 32'd2);
    checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 16'h0003, 2'd1, 1'b0);
    repeat (2) nextCycle();
    checkOutput("bp_c_ignored_occ", 32'(occupancy), 32'd2);
    checkOutput("bp_head_a", out_data, 32'h00000001);
    applyStimulus(1'b0, 16'h0, 2'd1, 1'b1);
    nextCycle();
    checkOutput("bp_head_b", out_data, 32'h00000002);
    checkOutput("bp_in_ready_back", 32'(in_ready), 32'd1);
    checkOutput("bp_occ_one", 32'(occupancy), 32'd1);
    nextCycle();
    checkOutput("bp_occ_empty", 32'(occupancy), 32'd0);

    // Streaming, one result per cycle
    pops_before = pop_count;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 16'($urandom), 2'($urandom_range(0, 3)), 1'b1);
      nextCycle();
      if (occupancy != 2'd1)
        checkOutput("stream_occ", 32'(occupancy), 32'd1);
    end
    applyStimulus(1'b0, 16'h0, 2'd0, 1'b1);
    nextCycle();
    checkOutput("stream_count", 32'(pop_count - pops_before), 32'd100);
    checkOutput("stream_occ_end", 32'(occupancy), 32'd0);

    // Asynchronous reset while stalled and full
    applyStimulus(1'b1, 16'h1111, 2'd0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 16'h2222, 2'd0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 16'h0, 2'd0, 1'b0);
    checkOutput("rst_pre_occ", 32'(occupancy), 32'd2);
    #2 Reset = 1'b1;
    #1;
    checkOutput("rst_async_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_async_occ", 32'(occupancy), 32'd0);
    checkOutput("rst_async_data", out_data, 32'd0);
    checkOutput("rst_async_neg", 32'(out_neg), 32'd0);
    nextCycle();
    #2 Reset = 1'b0;
    @(posedge Clk);
    #1;
    checkOutput("rst_release_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 16'hF00D, 2'd1, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 16'h0, 2'd0, 1'b1);
    checkOutput("rst_first_out", out_data, 32'hFFFFF00D);
    nextCycle();

    // Parameter sweep instances
    sw8_valid = 1'b1;  sw8_data = 8'hFF;  sw8_mode = 2'd3;
    sw16_valid = 1'b1; sw16_data = 16'hA5C3; sw16_mode = 2'd1;
    nextCycle();
    checkOutput("sw8_sign_shl", 32'(sw8_out), 32'h0000FFFE);
    checkOutput("sw16_sign_pass", 32'(sw16_out), 32'h0000A5C3);
    sw8_data = 8'h81; sw8_mode = 2'd2;
    sw16_mode = 2'd2;
    nextCycle();
    checkOutput("sw8_upper", 32'(sw8_out), 32'h00008100);
    checkOutput("sw16_upper_pass", 32'(sw16_out), 32'h0000A5C3);
    sw8_mode = 2'd1;
    sw16_mode = 2'd0;
    nextCycle();
    checkOutput("sw8_sign", 32'(sw8_out), 32'h0000FF81);
    checkOutput("sw16_zero_pass", 32'(sw16_out), 32'h0000A5C3);
    sw8_valid = 1'b0; sw16_valid = 1'b0;

    // Random handshake traffic
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
      nextCycle();
      if (occupancy > 2'd2)
        checkOutput("rand_occ_bound", 32'(occupancy), 32'd2);
    end
    applyStimulus(1'b0, 16'h0, 2'd0, 1'b1);
    repeat (4) nextCycle();
    checkOutput("rand_sb_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("rand_occ_end", 32'(occupancy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
